// File: rtl/sign_narrow_seq_pkg.sv
// Shared definitions for the sign_narrow_seq block.
// Contents: default word/immediate widths and the FSM state encodings
// (IDLE/SCAN/DONE) used by the top level.
package sign_narrow_seq_pkg;

    localparam int unsigned DEF_IN_W  = 32;
    localparam int unsigned DEF_OUT_W = 16;
    localparam int unsigned DEF_CW    = 6;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SCAN = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/sign_narrow_seq_if.sv
// Handshake bundle for sign_narrow_seq.
// Input side : in_valid, in_ready, in_data (signed word to narrow).
// Output side: out_valid, out_ready, out_imm (low OUT_W bits), out_width
//              (minimal signed width), out_fits (out_width <= OUT_W).
// master = producer/consumer around the block, slave = the block itself.
interface sign_narrow_seq_if
    import sign_narrow_seq_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned CW    = DEF_CW
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [CW-1:0]    out_width;
    logic             out_fits;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_imm, out_width, out_fits
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_imm, out_width, out_fits
    );
endinterface

// File: rtl/sign_run_counter.sv
// Counts the run of redundant sign bits in a captured word, one bit per cycle.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : restart the scan (idx = IN_W-2, red = 0)
//   en           : advance the scan by one bit
//   word         : captured word being scanned
//   red          : number of redundant sign bits found so far
//   mismatch     : word[idx] differs from the sign bit (run has ended)
//   idx_zero     : idx has reached bit 0 (last bit to examine)
module sign_run_counter #(
    parameter int unsigned IN_W = 32,
    parameter int unsigned CW   = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            en,
    input  logic [IN_W-1:0] word,
    output logic [CW-1:0]   red,
    output logic            mismatch,
    output logic            idx_zero
);
    localparam int unsigned IW = $clog2(IN_W);

    logic [IW-1:0] idx;

    assign mismatch = (word[idx] != word[IN_W-1]);
    assign idx_zero = (idx == '0);

    // idx parks at 0 instead of wrapping; the FSM leaves SCAN on that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            red <= '0;
        end else if (load) begin
            idx <= IW'(IN_W - 2);
            red <= '0;
        end else if (en && !mismatch) begin
            red <= red + CW'(1);
            if (!idx_zero) begin
                idx <= idx - IW'(1);
            end
        end
    end
endmodule

// File: rtl/sign_narrow_seq.sv
// Bit-serial inverse of immediate sign extension.
// Captures a signed IN_W word, scans its redundant sign bits one per cycle,
// then presents the truncated immediate, the minimal two's-complement width
// and a flag saying whether the value survives an OUT_W-bit round trip.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_data request side,
//                  out_valid/out_ready/out_imm/out_width/out_fits result side
module sign_narrow_seq
    import sign_narrow_seq_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic              clk,
    input  logic              reset_n,
    sign_narrow_seq_if.slave  bus
);
    logic [1:0]       state;
    logic [IN_W-1:0]  word;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_imm_q;
    logic [CW-1:0]    out_width_q;
    logic             out_fits_q;

    logic             accept;
    logic             scan_end;
    logic [CW-1:0]    red;
    logic             mismatch;
    logic             idx_zero;
    logic [CW-1:0]    red_final;
    logic [CW-1:0]    width_next;

    assign bus.in_ready = (state == ST_IDLE);
    assign accept       = (state == ST_IDLE) && bus.in_valid;
    assign scan_end     = (state == ST_SCAN) && (mismatch || idx_zero);

    sign_run_counter #(
        .IN_W (IN_W),
        .CW   (CW)
    ) u_run (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .en       (state == ST_SCAN),
        .word     (word),
        .red      (red),
        .mismatch (mismatch),
        .idx_zero (idx_zero)
    );

    // The counter's last increment lands on the same edge the outputs are
    // registered, so fold it in here rather than spending an extra cycle.
    always_comb begin
        red_final  = mismatch ? red : red + CW'(1);
        width_next = CW'(IN_W) - red_final;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            word        <= '0;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_width_q <= '0;
            out_fits_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        word  <= bus.in_data;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_end) begin
                        out_valid_q <= 1'b1;
                        out_imm_q   <= word[OUT_W-1:0];
                        out_width_q <= width_next;
                        out_fits_q  <= (width_next <= CW'(OUT_W));
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_width = out_width_q;
    assign bus.out_fits  = out_fits_q;
endmodule

// File: tb/tb_sign_narrow_seq.sv
// Scoreboard bench for sign_narrow_seq: the driver pushes reference results,
// a separate monitor pops and compares whenever out_valid rises, and also
// checks hold stability and the post-handoff return to idle.
module tb_sign_narrow_seq;
    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned CW    = 6;

    typedef struct {
        logic [15:0] imm;
        int          width;
        bit          fits;
        int          lat;
        longint      acc;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     ready_mode = 0;   // 0 random, 1 hold low, 2 always high
    exp_t   sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sign_narrow_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CW(CW)) bus ();

    sign_narrow_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Smallest width w such that the value equals the sign extension of its
    // low w bits, i.e. shifting right arithmetically by w-1 leaves 0 or -1.
    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        logic signed [31:0] s;
        logic signed [31:0] sh;
        int red;
        s = v;
        e.width = 32;
        for (int w = 1; w <= 32; w++) begin
            sh = s >>> (w - 1);
            if (sh == 0 || sh == -1) begin
                e.width = w;
                break;
            end
        end
        red    = 32 - e.width;
        e.imm  = v[15:0];
        e.fits = (e.width <= 16);
        e.lat  = (red + 1 < 31) ? red + 1 : 31;
        e.acc  = 0;
        return e;
    endfunction

    // Monitor: owns out_ready, compares each new result against the scoreboard.
    initial begin : monitor
        bit          busy;
        bit          prev_hs;
        exp_t        e;
        logic [15:0] h_imm;
        logic [5:0]  h_width;
        logic        h_fits;
        busy = 0;
        prev_hs = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy = 0;
                prev_hs = 0;
                bus.out_ready = 1'b0;
            end else begin
                if (prev_hs) begin
                    check("handoff_in_ready", bus.in_ready, 1);
                    check("handoff_out_valid", bus.out_valid, 0);
                end
                if (bus.out_valid) begin
                    check("in_ready_while_valid", bus.in_ready, 0);
                    if (!busy) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_result: actual width %0d required none", bus.out_width);
                        end else begin
                            e = sb.pop_front();
                            check("out_imm", bus.out_imm, e.imm);
                            check("out_width", bus.out_width, e.width);
                            check("out_fits", bus.out_fits, e.fits);
                            check("latency", cyc - e.acc, e.lat);
                        end
                        h_imm = bus.out_imm;
                        h_width = bus.out_width;
                        h_fits = bus.out_fits;
                    end else begin
                        check("hold_imm", bus.out_imm, h_imm);
                        check("hold_width", bus.out_width, h_width);
                        check("hold_fits", bus.out_fits, h_fits);
                    end
                    case (ready_mode)
                        1:       bus.out_ready = 1'b0;
                        2:       bus.out_ready = 1'b1;
                        default: bus.out_ready = ($urandom_range(0, 2) != 0);
                    endcase
                    prev_hs = bus.out_ready;
                    busy = !bus.out_ready;
                end else begin
                    bus.out_ready = (ready_mode == 1) ? 1'b0 : 1'(($urandom_range(0, 1)));
                    prev_hs = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] v, output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = v;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: actual in_ready 0 required 1");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e = model(v);
        e.acc = cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.in_data = $urandom;   // post-capture changes must be ignored
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.out_valid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", sb.size(), 0);
    endtask

    initial begin : stim
        int          w;
        int          t;
        logic [31:0] v;
        logic signed [31:0] s;
        logic [31:0] dir[8];
        dir = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_FFFF,
                32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0005};
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_imm", bus.out_imm, 0);
        check("rst_out_width", bus.out_width, 0);
        check("rst_out_fits", bus.out_fits, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (dir[i]) send(dir[i], w);
        drain();

        // Reset in the middle of a long scan discards the word.
        send(32'h0000_0000, w);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_imm", bus.out_imm, 0);
        check("mid_rst_out_width", bus.out_width, 0);
        check("mid_rst_out_fits", bus.out_fits, 0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        send(32'h0000_7FFF, w);
        check("accept_after_reset_wait", w, 0);
        drain();

        // Backpressure: result held while out_ready stays low.
        ready_mode = 1;
        send(32'h0000_0005, w);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", bus.out_valid, 1);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 32'hDEAD_BEEF;
        check("bp_in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_valid_held", bus.out_valid, 1);
        check("bp_width_held", bus.out_width, 4);
        check("bp_fits_held", bus.out_fits, 1);
        check("bp_imm_held", bus.out_imm, 16'h0005);
        ready_mode = 2;
        drain();

        // Random words with a random-length sign run.
        ready_mode = 0;
        for (int n = 0; n < 60; n++) begin
            v = $urandom;
            s = v;
            s = s >>> $urandom_range(0, 31);
            send(s, w);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sign_narrow_seq.md
Name: sign_narrow_seq

Overview:
- Inverse of the datapath's 16→32 immediate sign extension.
- Accepts a full-width signed word and returns its truncated immediate, the minimal two's-complement width that holds the value, and a lossless-fit flag.
- Works bit-serially: it scans redundant sign bits one per cycle.
- Sits beside the ALU result path, where the assembler-check/immediate-compaction logic uses it to decide whether a value can be re-encoded as a 16-bit immediate.

Parameters:
- IN_W, 32: input word width; must be greater than OUT_W.
- OUT_W, 16: target immediate width; out_fits compares against this.
- CW, 6: width of out_width; equals clog2(IN_W)+1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- in_data  input  IN_W  signed word to narrow
- out_valid  output  1  result is valid
- out_ready  input  1  consumer takes the result
- out_imm  output  OUT_W  captured word bits [OUT_W-1:0]
- out_width  output  CW  minimal signed width, range 1..IN_W
- out_fits  output  1  1 when out_width <= OUT_W, meaning sign-extending out_imm reproduces in_data

Behaviour:
Interface: one clock (clk); reset_n is asynchronous and active-low.

Reset:
- State goes to IDLE.
- out_valid, out_imm, out_width, out_fits and all internal registers go to 0.
- in_ready = (state==IDLE), so it reads 1 while reset is held.
- Reset asserted mid-scan or in DONE aborts and discards the word; there is no output.

States:
- IDLE
  - in_ready=1.
  - On in_valid&in_ready at an edge: capture in_data into word reg, idx=IN_W-2, red=0, go to SCAN.
- SCAN
  - in_ready=0, out_valid=0.
  - Each cycle compare word[idx] with word[IN_W-1].
  - Equal and idx>0: red+=1, idx-=1, stay in SCAN.
  - Equal and idx==0: red+=1, go to DONE.
  - Not equal: go to DONE, red unchanged.
- DONE
  - out_valid=1.
  - out_width = IN_W - red.
  - out_fits = (out_width <= OUT_W).
  - out_imm = word[OUT_W-1:0], always the truncated value, even when out_fits=0.
  - All outputs are registered and held stable until out_valid&out_ready, then go to IDLE.
  - The block does not accept a new word in the same cycle it hands off a result.

Latency and arithmetic rules:
- Latency from the accept edge to out_valid is min(red+1, IN_W-1) cycles. The worst case is 31 cycles, for all-zeros or all-ones inputs.
- Throughput is one word per latency+2 cycles at most.
- red ranges 0..IN_W-1, so out_width ranges 1..IN_W. No wrap-around is possible, because idx stops at 0.
- in_data changes after capture are ignored.
- Holding out_ready=1 early has no effect until DONE.
- out_valid must never drop without a handshake.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, SCAN=2'b01, DONE=2'b10
  - default IN_W/OUT_W
- Natural sub-module: sign_run_counter. It holds the idx down-counter and the red up-counter with load/enable/terminal outputs (mismatch, idx_zero).
- The top level holds the FSM, capture register and output registers.

Test Plan:
- Reset with reset_n=0 mid-scan of 0x00000000 → in_ready=1, out_valid=0, all outputs 0; a new word is accepted immediately after release.
- in_data=0x00007FFF → after 17 cycles out_valid=1, out_width=16, out_fits=1, out_imm=0x7FFF.
- in_data=0x00008000 → after 16 cycles out_width=17, out_fits=0, out_imm=0x8000.
- in_data=0xFFFF8000 → out_width=16, out_fits=1, out_imm=0x8000; in_data=0xFFFFFFFF → after 31 cycles out_width=1, out_fits=1, out_imm=0xFFFF.
- in_data=0x80000000 → after 1 cycle out_width=32, out_fits=0, out_imm=0x0000; in_data=0x40000000 → after 1 cycle out_width=32, out_fits=0.
- Backpressure: in_data=0x00000005 with out_ready=0 for 10 cycles → out_valid and outputs stay at out_width=4, out_fits=1, out_imm=0x0005; in_ready stays 0 and a pulsed in_valid is ignored; after out_ready=1 for one cycle, in_ready returns to 1 the next cycle.
